// File: rtl/uart_core_param.sv
// rtl/uart_core_param.sv - parametrised full-duplex UART with FIFOs, parity, 16x RX oversampling
//
// uart_fifo: synchronous show-ahead FIFO.
//   i_push/i_data write, i_pop reads the head shown on o_data.
//   A push onto a full FIFO is taken only when a pop happens in the same cycle.
//   o_count holds 0..DEPTH, so full and empty are distinguishable.
//
// uart_core_param: UART transceiver.
//   clk, rst                   clock, asynchronous active-high reset
//   i_baud_div                 oversample tick period minus 1 (clk cycles)
//   i_parity_mode, i_stop2     frame format (00/11 none, 01 even, 10 odd; stop2 = 2 TX stop bits)
//   i_loopback                 RX fed from the internal TX line, o_tx_serial held high
//   i_rx_serial, o_tx_serial   serial pins
//   i_tx_valid/i_tx_data/o_tx_ready                TX FIFO push side
//   o_rx_valid/o_rx_data/o_rx_err/i_rx_ready      RX FIFO pop side, err = {parity, framing}
//   o_rx_overrun, i_clear_err  sticky dropped-frame flag and its clear
//   o_tx_busy, o_rx_count, o_tx_count             status

module uart_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // When full, the slot being written is the one being popped this cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end
endmodule

module uart_core_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              i_baud_div,
  input  logic [1:0]                    i_parity_mode,
  input  logic                          i_stop2,
  input  logic                          i_loopback,
  input  logic                          i_rx_serial,
  output logic                          o_tx_serial,
  input  logic                          i_tx_valid,
  input  logic [DATA_W-1:0]             i_tx_data,
  output logic                          o_tx_ready,
  input  logic                          i_rx_ready,
  output logic                          o_rx_valid,
  output logic [DATA_W-1:0]             o_rx_data,
  output logic [1:0]                    o_rx_err,
  output logic                          o_rx_overrun,
  input  logic                          i_clear_err,
  output logic                          o_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_rx_count,
  output logic [$clog2(FIFO_DEPTH):0]   o_tx_count
);
  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

  // Oversample tick. Comparing with >= makes a shrunken divisor wrap on the next cycle.
  logic [DIV_W-1:0] r_tick_cnt;
  logic             w_tick;
  assign w_tick = (r_tick_cnt >= i_baud_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // TX FIFO
  logic [DATA_W-1:0] w_txf_data;
  logic              w_txf_empty;
  logic              w_txf_full;
  logic              w_tx_pop;

  uart_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (i_tx_valid && !w_txf_full),
    .i_data  (i_tx_data),
    .i_pop   (w_tx_pop),
    .o_data  (w_txf_data),
    .o_empty (w_txf_empty),
    .o_full  (w_txf_full),
    .o_count (o_tx_count)
  );
  assign o_tx_ready = !w_txf_full;

  // TX FSM
  tx_state_t         r_tx_state;
  logic [3:0]        r_tx_sub;
  logic [3:0]        r_tx_bitcnt;
  logic [DATA_W-1:0] r_tx_shift;
  logic [1:0]        r_tx_par_mode;
  logic              r_tx_stop2;
  logic              r_tx_parity;
  logic              r_tx_serial;
  logic              w_tx_bit_end;
  logic              w_tx_last_stop;

  assign w_tx_bit_end   = w_tick && (r_tx_sub == 4'd15);
  assign w_tx_last_stop = !r_tx_stop2 || (r_tx_bitcnt == 4'd1);
  // Load a new frame from IDLE, or straight out of the final stop bit with no gap.
  assign w_tx_pop = !w_txf_empty && w_tick &&
                    ((r_tx_state == TX_IDLE) ||
                     ((r_tx_state == TX_STOP) && w_tx_bit_end && w_tx_last_stop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state    <= TX_IDLE;
      r_tx_sub      <= '0;
      r_tx_bitcnt   <= '0;
      r_tx_shift    <= '0;
      r_tx_par_mode <= '0;
      r_tx_stop2    <= 1'b0;
      r_tx_parity   <= 1'b0;
      r_tx_serial   <= 1'b1;
    end else if (w_tx_pop) begin
      r_tx_state    <= TX_START;
      r_tx_serial   <= 1'b0;
      r_tx_sub      <= '0;
      r_tx_bitcnt   <= '0;
      r_tx_shift    <= w_txf_data;
      r_tx_par_mode <= i_parity_mode;
      r_tx_stop2    <= i_stop2;
      // Even: bit equals XOR of data; odd: its complement.
      r_tx_parity   <= (^w_txf_data) ^ i_parity_mode[1];
    end else if (w_tick) begin
      r_tx_sub <= r_tx_sub + 4'd1;
      case (r_tx_state)
        TX_START: if (w_tx_bit_end) begin
          r_tx_state  <= TX_DATA;
          r_tx_serial <= r_tx_shift[0];
        end
        TX_DATA: if (w_tx_bit_end) begin
          if (r_tx_bitcnt == LAST_BIT) begin
            r_tx_bitcnt <= '0;
            if (r_tx_par_mode[0] ^ r_tx_par_mode[1]) begin
              r_tx_state  <= TX_PARITY;
              r_tx_serial <= r_tx_parity;
            end else begin
              r_tx_state  <= TX_STOP;
              r_tx_serial <= 1'b1;
            end
          end else begin
            r_tx_bitcnt <= r_tx_bitcnt + 4'd1;
            r_tx_shift  <= r_tx_shift >> 1;
            r_tx_serial <= r_tx_shift[1];
          end
        end
        TX_PARITY: if (w_tx_bit_end) begin
          r_tx_state  <= TX_STOP;
          r_tx_serial <= 1'b1;
        end
        TX_STOP: if (w_tx_bit_end) begin
          if (w_tx_last_stop) r_tx_state  <= TX_IDLE;
          else                r_tx_bitcnt <= 4'd1;
        end
        default: begin
          r_tx_sub    <= '0;
          r_tx_serial <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx_busy   = (r_tx_state != TX_IDLE);
  assign o_tx_serial = i_loopback ? 1'b1 : r_tx_serial;

  // RX input: synchronise the pin, then pick loopback source.
  logic r_sync1;
  logic r_sync2;
  logic w_rx_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx_serial;
      r_sync2 <= r_sync1;
    end
  end
  assign w_rx_in = i_loopback ? r_tx_serial : r_sync2;

  // RX FSM. Sub-count is ticks since the bit boundary estimate; samples land mid-bit.
  rx_state_t           r_rx_state;
  logic [3:0]          r_rx_sub;
  logic [3:0]          r_rx_bitcnt;
  logic [DATA_W-1:0]   r_rx_shift;
  logic [1:0]          r_rx_par_mode;
  logic                r_rx_par_err;
  logic                r_rx_push;
  logic [DATA_W+1:0]   r_rx_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state    <= RX_IDLE;
      r_rx_sub      <= '0;
      r_rx_bitcnt   <= '0;
      r_rx_shift    <= '0;
      r_rx_par_mode <= '0;
      r_rx_par_err  <= 1'b0;
      r_rx_push     <= 1'b0;
      r_rx_word     <= '0;
    end else begin
      r_rx_push <= 1'b0;
      if (w_tick) begin
        r_rx_sub <= r_rx_sub + 4'd1;
        case (r_rx_state)
          RX_IDLE: begin
            r_rx_sub <= '0;
            if (!w_rx_in) begin
              r_rx_state    <= RX_START;
              r_rx_par_mode <= i_parity_mode;
            end
          end
          RX_START: if (r_rx_sub == 4'd7) begin
            r_rx_sub    <= '0;
            r_rx_bitcnt <= '0;
            r_rx_state  <= w_rx_in ? RX_IDLE : RX_DATA;
          end
          RX_DATA: if (r_rx_sub == 4'd15) begin
            r_rx_shift <= {w_rx_in, r_rx_shift[DATA_W-1:1]};
            if (r_rx_bitcnt == LAST_BIT) begin
              r_rx_par_err <= 1'b0;
              r_rx_state   <= (r_rx_par_mode[0] ^ r_rx_par_mode[1]) ? RX_PARITY : RX_STOP;
            end else begin
              r_rx_bitcnt <= r_rx_bitcnt + 4'd1;
            end
          end
          RX_PARITY: if (r_rx_sub == 4'd15) begin
            r_rx_par_err <= w_rx_in != ((^r_rx_shift) ^ r_rx_par_mode[1]);
            r_rx_state   <= RX_STOP;
          end
          RX_STOP: if (r_rx_sub == 4'd15) begin
            r_rx_push  <= 1'b1;
            r_rx_word  <= {r_rx_par_err, !w_rx_in, r_rx_shift};
            r_rx_state <= w_rx_in ? RX_IDLE : RX_BREAK;
          end
          default: begin
            r_rx_sub <= '0;
            if (w_rx_in) r_rx_state <= RX_IDLE;
          end
        endcase
      end
    end
  end

  // RX FIFO and overrun
  logic [DATA_W+1:0] w_rxf_data;
  logic              w_rxf_empty;
  logic              w_rxf_full;
  logic              r_overrun;

  uart_fifo #(.W(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_rx_push),
    .i_data  (r_rx_word),
    .i_pop   (i_rx_ready),
    .o_data  (w_rxf_data),
    .o_empty (w_rxf_empty),
    .o_full  (w_rxf_full),
    .o_count (o_rx_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    r_overrun <= 1'b0;
    else if (r_rx_push && w_rxf_full && !i_rx_ready) r_overrun <= 1'b1;
    else if (i_clear_err)                       r_overrun <= 1'b0;
  end

  assign o_rx_overrun = r_overrun;
  assign o_rx_valid   = !w_rxf_empty;
  assign o_rx_data    = w_rxf_empty ? '0 : w_rxf_data[DATA_W-1:0];
  assign o_rx_err     = w_rxf_empty ? 2'b00 : w_rxf_data[DATA_W+1:DATA_W];
endmodule

// File: tb/tb_uart_core_param.sv
// tb/tb_uart_core_param.sv - self-checking bench for uart_core_param
module tb_uart_core_param;
  localparam int T   = 4;        // clk per tick with divisor 3
  localparam int BIT = 16 * T;   // clk per bit

  logic clk = 0;
  logic rst = 1;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic [15:0] baud_div = 16'd3;
  logic [1:0]  parity_mode = 2'b00;
  logic        stop2 = 0, loopback = 0, rx_serial = 1;
  logic        tx_valid = 0, rx_ready = 1, clear_err = 0;
  logic [7:0]  tx_data = 0;
  logic        tx_ready, rx_valid, rx_overrun, tx_busy, tx_serial;
  logic [7:0]  rx_data;
  logic [1:0]  rx_err;
  logic [4:0]  rx_count, tx_count;

  logic        d7_stop2 = 1, d7_tx_valid = 0;
  logic [6:0]  d7_tx_data = 0;
  logic        d7_tx_ready, d7_rx_valid, d7_rx_overrun, d7_tx_busy, d7_tx_serial;
  logic [6:0]  d7_rx_data;
  logic [1:0]  d7_rx_err;
  logic [2:0]  d7_rx_count, d7_tx_count;

  logic [9:0]  exp_q[$];
  logic        exp_ovr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_core_param #(.DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .i_baud_div(baud_div), .i_parity_mode(parity_mode),
    .i_stop2(stop2), .i_loopback(loopback), .i_rx_serial(rx_serial), .o_tx_serial(tx_serial),
    .i_tx_valid(tx_valid), .i_tx_data(tx_data), .o_tx_ready(tx_ready), .i_rx_ready(rx_ready),
    .o_rx_valid(rx_valid), .o_rx_data(rx_data), .o_rx_err(rx_err), .o_rx_overrun(rx_overrun),
    .i_clear_err(clear_err), .o_tx_busy(tx_busy), .o_rx_count(rx_count), .o_tx_count(tx_count)
  );

  uart_core_param #(.DATA_W(7), .FIFO_DEPTH(4), .DIV_W(16)) dut7 (
    .clk(clk), .rst(rst), .i_baud_div(baud_div), .i_parity_mode(2'b00),
    .i_stop2(d7_stop2), .i_loopback(1'b0), .i_rx_serial(1'b1), .o_tx_serial(d7_tx_serial),
    .i_tx_valid(d7_tx_valid), .i_tx_data(d7_tx_data), .o_tx_ready(d7_tx_ready), .i_rx_ready(1'b1),
    .o_rx_valid(d7_rx_valid), .o_rx_data(d7_rx_data), .o_rx_err(d7_rx_err), .o_rx_overrun(d7_rx_overrun),
    .i_clear_err(1'b0), .o_tx_busy(d7_tx_busy), .o_rx_count(d7_rx_count), .o_tx_count(d7_tx_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model of the RX FIFO contents: frames enter when the bench starts their stop bit.
  task automatic model_push(input logic [9:0] word);
    if (exp_q.size() >= 16 && !rx_ready) exp_ovr = 1;
    else exp_q.push_back(word);
  endtask

  function automatic logic line_of(input bit sel);
    return sel ? d7_tx_serial : tx_serial;
  endfunction

  // Drive an external frame LSB first, one bit per 16 ticks.
  task automatic send_ext(input logic [15:0] bits, input int n, input logic [9:0] word);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) model_push(word);
      rx_serial = bits[i];
      repeat (BIT) @(posedge clk);
    end
    rx_serial = 1;
  endtask

  // Wait for a start edge on a TX line and sample nb bits at mid-bit.
  task automatic cap(input bit sel, input int nb, output logic [15:0] bits, output int t0);
    logic prev;
    int   n;
    bit   got;
    bits = '0; got = 0; n = 0;
    @(negedge clk);
    prev = line_of(sel);
    while (!got && n < 20000) begin
      @(negedge clk); n++;
      if (prev && !line_of(sel)) got = 1;
      else prev = line_of(sel);
    end
    chk("tx_start_seen", got, 1);
    t0 = cyc;
    if (got) for (int k = 0; k < nb; k++) begin
      while (cyc < t0 + (16 * k + 8) * T) @(negedge clk);
      bits[k] = line_of(sel);
    end
  endtask

  task automatic wait_idle(input bit sel, output int t1);
    int n = 0;
    while ((sel ? d7_tx_busy : tx_busy) && n < 20000) begin @(negedge clk); n++; end
    chk("tx_idle_seen", sel ? d7_tx_busy : tx_busy, 0);
    t1 = cyc;
  endtask

  // Compare process: every popped RX entry against the model, plus per-cycle rules.
  always @(negedge clk) begin
    if (!rst) begin
      if (loopback) chk("loop_line_high", tx_serial, 1);
      chk("tx_ready_rule", tx_ready, tx_count != 5'd16);
      if (rx_valid && rx_ready) begin
        chk("rx_model_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          logic [9:0] e;
          e = exp_q.pop_front();
          chk("rx_data", rx_data, e[7:0]);
          chk("rx_err", rx_err, e[9:8]);
        end
      end
    end
  end

  initial begin
    logic [15:0] bits;
    int t0, t1, tprev, n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_serial", tx_serial, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_overrun", rx_overrun, 0);
    chk("rst_counts", {rx_count, tx_count}, 0);
    chk("rst_rx_data_err", {rx_err, rx_data}, 0);
    rst = 0;
    repeat (4) @(negedge clk);

    // Loopback 8N1, 0x55
    loopback = 1; rx_ready = 0;
    tx_data = 8'h55; tx_valid = 1; model_push({2'b00, 8'h55});
    t0 = cyc;
    @(negedge clk); tx_valid = 0;
    n = 0;
    while (!tx_busy && n < 10) begin @(negedge clk); n++; end
    chk("start_latency_le4", (cyc - (t0 + 1)) <= 4, 1);
    t1 = cyc;
    while (cyc < t1 + 600) @(negedge clk);
    chk("loop_not_early", rx_valid, 0);
    while (cyc < t1 + 640) @(negedge clk);
    chk("loop_rx_valid", rx_valid, 1);
    chk("loop_rx_data", rx_data, 8'h55);
    chk("loop_rx_err", rx_err, 2'b00);
    chk("loop_busy_low", tx_busy, 0);
    rx_ready = 1;
    repeat (4) @(negedge clk);
    loopback = 0;

    // Even parity TX of 0xA7: five ones, so parity bit is 1; 11 bits = 176 ticks
    parity_mode = 2'b01;
    fork
      cap(0, 11, bits, t0);
      begin @(negedge clk); tx_data = 8'hA7; tx_valid = 1; @(negedge clk); tx_valid = 0; end
    join
    chk("par_start", bits[0], 0);
    chk("par_data", bits[8:1], 8'hA7);
    chk("par_bit", bits[9], 1);
    chk("par_stop", bits[10], 1);
    wait_idle(0, t1);
    chk("par_frame_clk", t1 - t0, 176 * T);

    // External frame with inverted parity bit
    send_ext({1'b1, 1'b0, 8'hA7, 1'b0}, 11, {2'b10, 8'hA7});
    repeat (BIT) @(negedge clk);
    parity_mode = 2'b00;

    // Framing error followed by a held-low break
    rx_ready = 0;
    send_ext({1'b0, 8'h81, 1'b0}, 10, {2'b01, 8'h81});
    rx_serial = 0;
    repeat (40 * T) @(negedge clk);
    chk("break_one_entry", rx_count, 1);
    rx_serial = 1;
    repeat (BIT) @(negedge clk);
    send_ext({1'b1, 8'h3C, 1'b0}, 10, {2'b00, 8'h3C});
    repeat (BIT) @(negedge clk);
    chk("break_then_clean", rx_count, 2);
    rx_ready = 1;
    repeat (4) @(negedge clk);

    // Start glitch low for 4 ticks
    rx_ready = 0;
    rx_serial = 0;
    repeat (4 * T) @(negedge clk);
    rx_serial = 1;
    repeat (11 * BIT) @(negedge clk);
    chk("glitch_ignored", rx_count, 0);
    rx_ready = 1;

    // Overrun: 18 frames into a 16-deep FIFO with no consumer
    rx_ready = 0;
    for (int i = 0; i < 18; i++) begin
      logic [7:0] d;
      d = 8'(i * 17 + 3);
      send_ext({1'b1, d, 1'b0}, 10, {2'b00, d});
    end
    repeat (BIT) @(negedge clk);
    chk("ovr_count", rx_count, 16);
    chk("ovr_flag_model", rx_overrun, exp_ovr);
    chk("ovr_flag", rx_overrun, 1);
    clear_err = 1; @(negedge clk); clear_err = 0; exp_ovr = 0;
    chk("ovr_cleared", rx_overrun, 0);
    rx_ready = 1;
    repeat (40) @(negedge clk);
    chk("ovr_drained", rx_count, 0);

    // Back-to-back TX: lead 0xFF then 0x00..0x10 pushed into a busy transmitter
    fork
      begin
        for (int f = 0; f < 18; f++) begin
          cap(0, 10, bits, t0);
          chk("b2b_start", bits[0], 0);
          chk("b2b_data", bits[8:1], (f == 0) ? 8'hFF : 8'(f - 1));
          chk("b2b_stop", bits[9], 1);
          if (f > 0) chk("b2b_no_gap", t0 - tprev, 160 * T);
          tprev = t0;
        end
      end
      begin
        @(negedge clk); tx_data = 8'hFF; tx_valid = 1; @(negedge clk); tx_valid = 0;
        n = 0;
        while (!tx_busy && n < 10) begin @(negedge clk); n++; end
        for (int i = 0; i < 17; i++) begin
          @(negedge clk); tx_data = 8'(i); tx_valid = 1;
          if (i == 16) begin
            chk("tx_count_full", tx_count, 16);
            chk("tx_ready_full", tx_ready, 0);
            repeat (20) @(negedge clk);
            chk("tx_push_ignored", tx_count, 16);
            n = 0;
            while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
            chk("tx_ready_return", tx_ready, 1);
          end
        end
        @(negedge clk); tx_valid = 0;
      end
    join
    wait_idle(0, t1);

    // Reset mid-frame, then DATA_W=7 with two stop bits
    @(negedge clk); tx_data = 8'h00; tx_valid = 1; @(negedge clk); tx_valid = 0;
    repeat (200) @(negedge clk);
    rst = 1;
    #1;
    chk("midrst_tx_serial", tx_serial, 1);
    chk("midrst_counts", {rx_count, tx_count}, 0);
    chk("midrst_busy", tx_busy, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    fork
      cap(1, 10, bits, t0);
      begin @(negedge clk); d7_tx_data = 7'h2B; d7_tx_valid = 1; @(negedge clk); d7_tx_valid = 0; end
    join
    chk("d7_start", bits[0], 0);
    chk("d7_data", bits[7:1], 7'h2B);
    chk("d7_stops", bits[9:8], 2'b11);
    wait_idle(1, t1);
    chk("d7_frame_clk", t1 - t0, 16 * 10 * T);
    chk("post_rst_line", tx_serial, 1);

    chk("model_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
